if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel with variable-latency responses.
- Buffers returned instructions in a small FIFO and presents {pc, instr, valid} to IF/ID.
- Honours decode-stage stall and execute-stage redirect (branch/jump); discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; also the credit limit for outstanding + buffered fetches (power of 2, ≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  1 = IF/ID holding; do not pop the head entry.
- redirect  input  1  1 = control-flow change; flush and refetch.
- redirect_pc  input  32  new fetch address; bits[1:0] forced to 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address (word aligned).
- imem_rsp_valid  input  1  response valid; in order, no backpressure.
- imem_rsp_data  input  32  returned instruction.
- pc_out  output  32  PC of head instruction, to IF/ID pc_in.
- instr_out  output  32  head instruction, to IF/ID instr_in.
- instr_valid  output  1  head entry valid.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, pc_out=0, instr_out=0, instr_valid=0.
  - Instruction memory shares the same reset, so there are no pre-reset responses.
- Request issue:
  - imem_req_valid = !redirect && (outstanding + count − pop) < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - Handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^32); outstanding++; the request PC is pushed onto an internal in-order PC tag queue of depth FIFO_DEPTH.
  - Address is held stable while valid && !ready.
- Response:
  - Each imem_rsp_valid pops the PC tag queue and decrements outstanding.
  - If drop_cnt>0: discard the response, drop_cnt−−.
  - Otherwise write {tag_pc, imem_rsp_data} into the FIFO.
  - The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output:
  - pc_out/instr_out = FIFO head; instr_valid = (count != 0).
  - When the FIFO is empty: pc_out=0, instr_out=0 (bubble, decodes to no-op control).
  - pop = instr_valid && !stall && !redirect.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Latency: with single-cycle memory, a request accepted in cycle N produces instr_valid in cycle N+2. Sustained throughput is 1 instruction/cycle when stall=0 and the memory is always ready.
- Redirect (highest priority, single cycle):
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - FIFO cleared; no pop; imem_req_valid=0 that cycle.
  - drop_cnt = outstanding − imem_rsp_valid, because a response arriving in the redirect cycle is itself discarded.
  - Fetch at the new PC starts the next cycle.
- Back-to-back redirect: the second redirect recomputes drop_cnt from the current outstanding and overrides the first target.
- Redirect + stall in the same cycle: redirect wins.
- Stall with a full FIFO: requests stop via credit; head entry is held unchanged.
- Reset mid-operation: all state is cleared immediately; the first request after rst_n deassert is to RESET_PC.

Test Plan:
- Reset release, RESET_PC=0, memory 1-cycle always-ready, stall=0 → requests to 0x0,0x4,0x8… on consecutive cycles; instr_valid first high 2 cycles after the first request; pc_out increments by 4 each cycle.
- Hold stall=1 for 10 cycles → at most 4 requests outstanding+buffered; pc_out/instr_out frozen; on release, instructions emerge in order with no gap or duplicate.
- imem_req_ready=0 for 3 cycles with valid high → imem_req_addr stable at 0x10; fetch_pc advances only on the handshake.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x200 → both old responses discarded; the next instr_valid has pc_out=0x200 with the correct data; no instruction from 0x8/0xC appears.
- redirect_pc=0x103 → imem_req_addr=0x100.
- Redirect in the same cycle as imem_rsp_valid and stall=1 → FIFO empty next cycle; that response is dropped; drop_cnt = outstanding−1.
- Assert rst_n=0 mid-stream with the FIFO full → all outputs 0 immediately; refetch starts from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the fetch
// PC, issues in-order word fetches over a valid/ready request channel, tags
// each request with its PC, and buffers the variable-latency responses in a
// small FIFO whose head is presented to IF/ID as {pc, instr, valid}.
//
// A redirect from execute flushes the buffer, retargets the fetch PC and
// arms a drop counter so responses to requests already in flight are
// discarded instead of reaching decode.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  buffer entries and credit limit for outstanding + buffered
//               fetches (power of two, >= 2)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   stall            IF/ID holding; head entry is not consumed
//   redirect         control-flow change; flush and refetch from redirect_pc
//   redirect_pc      new fetch address (low two bits ignored)
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    word-aligned fetch address
//   imem_rsp_valid   in-order response strobe (no backpressure)
//   imem_rsp_data    returned instruction word
//   pc_out           PC of head instruction (0 when empty)
//   instr_out        head instruction (0 when empty)
//   instr_valid      head entry valid
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

    // Control state
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;

    // Data storage (not reset; only read when the matching control says valid)
    logic [31:0] tag_q      [FIFO_DEPTH];
    logic [31:0] fifo_pc    [FIFO_DEPTH];
    logic [31:0] fifo_instr [FIFO_DEPTH];

    logic        req_fire;
    logic        rsp_drop;
    logic        fifo_push;
    logic        pop;
    logic [CW:0] credit_used;

    // ---------------- request side ----------------
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && !stall && !redirect;

    // Credit covers everything fetched but not yet consumed; a head entry
    // leaving this cycle frees its slot immediately so a streaming pipe
    // never bubbles.
    always_comb begin
        credit_used = {1'b0, outstanding} + {1'b0, count} - (CW + 1)'(pop);
    end

    // rst_n gates the request so nothing is offered while held in reset.
    assign imem_req_valid = rst_n && !redirect && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // ---------------- response side ----------------
    // A response landing in the redirect cycle belongs to the old stream too.
    assign rsp_drop  = redirect || (drop_cnt != '0);
    assign fifo_push = imem_rsp_valid && !rsp_drop;

    // ---------------- output ----------------
    assign pc_out    = instr_valid ? fifo_pc[fifo_rd]    : '0;
    assign instr_out = instr_valid ? fifo_instr[fifo_rd] : '0;

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            // Tag queue keeps its position across a redirect: stale tags
            // still have to be retired by their (dropped) responses.
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (req_fire)      tag_wr <= tag_wr + 1'b1;
            if (imem_rsp_valid) tag_rd <= tag_rd + 1'b1;

            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
                count    <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                if (fifo_push) fifo_wr <= fifo_wr + 1'b1;
                if (pop)       fifo_rd <= fifo_rd + 1'b1;
                count <= count + CW'(fifo_push) - CW'(pop);
            end
        end
    end

    // ---------------- data registers ----------------
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= fetch_pc;
        if (fifo_push) begin
            fifo_pc[fifo_wr]    <= tag_q[tag_rd];
            fifo_instr[fifo_wr] <= imem_rsp_data;
        end
    end

    // The credit rule makes these unreachable with a well-behaved memory.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && !pop && count == FULL_C));
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    // Reference model: memory requests in flight, plus the architectural
    // view of the instruction stream (next PC decode should see, next PC
    // that should be requested, and how many good instructions are waiting).
    req_t        memq[$];
    int          cyc;
    int          last_due;
    int          lat;
    int          exp_buf;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;

    int vectors;
    int miscompares;

    // Values sampled on the last step
    logic        s_valid;
    logic        s_rv;
    logic [31:0] s_pc;
    logic [31:0] s_addr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model and
    // the memory behind the edge.
    task automatic step();
        logic pp;
        logic hs;
        logic rsp_now;
        logic head_stale;
        int   credit;
        int   due;
        @(negedge clk);
        pp     = (exp_buf != 0) && !stall && !redirect;
        credit = memq.size() + exp_buf - (pp ? 1 : 0);
        chk1("instr_valid", instr_valid, exp_buf != 0);
        if (exp_buf != 0) begin
            chk32("pc_out", pc_out, exp_pc);
            chk32("instr_out", instr_out, memfn(exp_pc));
        end else begin
            chk32("pc_out_bubble", pc_out, 32'h0);
            chk32("instr_out_bubble", instr_out, 32'h0);
        end
        chk1("req_valid", imem_req_valid, !redirect && (credit < DEPTH));
        chk32("req_addr", imem_req_addr, exp_req);
        s_valid = instr_valid;
        s_pc    = pc_out;
        s_addr  = imem_req_addr;
        s_rv    = imem_req_valid;
        hs      = imem_req_valid && imem_req_ready;

        @(posedge clk);
        #1;
        rsp_now    = imem_rsp_valid;
        head_stale = (memq.size() > 0) ? memq[0].stale : 1'b1;
        if (redirect) begin
            exp_buf = 0;
            foreach (memq[i]) memq[i].stale = 1'b1;
            exp_pc  = {redirect_pc[31:2], 2'b00};
            exp_req = {redirect_pc[31:2], 2'b00};
        end else begin
            if (rsp_now && !head_stale) exp_buf++;
            if (pp) begin
                exp_buf--;
                exp_pc = exp_pc + 32'd4;
            end
            if (hs) exp_req = exp_req + 32'd4;
        end
        if (rsp_now && memq.size() > 0) void'(memq.pop_front());
        if (hs) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: s_addr, stale: redirect, due: due});
        end
        cyc++;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Asynchronous reset pulse between edges; memory resets with the DUT.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk32("rst_pc_out", pc_out, 32'h0);
        chk32("rst_instr_out", instr_out, 32'h0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        memq.delete();
        imem_rsp_valid = 1'b0;
        exp_buf  = 0;
        exp_pc   = RESET_PC;
        exp_req  = RESET_PC;
        last_due = cyc;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        logic        found;
        logic [31:0] hold_pc;
        vectors        = 0;
        miscompares    = 0;
        cyc            = 0;
        last_due       = 0;
        lat            = 1;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        do_reset();

        // Streaming from reset, single-cycle always-ready memory
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) begin
                chk1("first_req_valid", s_rv, 1'b1);
                chk32("first_req_addr", s_addr, RESET_PC);
            end
            if (k == 1) chk1("valid_before_lat", s_valid, 1'b0);
            if (k == 2) begin
                chk1("valid_at_lat2", s_valid, 1'b1);
                chk32("first_pc", s_pc, RESET_PC);
            end
            if (k == 5) chk32("stream_pc", s_pc, RESET_PC + 32'd12);
        end

        // Stall for 10 cycles: head frozen, credit caps fetches
        stall   = 1'b1;
        hold_pc = exp_pc;
        for (int k = 0; k < 10; k++) step();
        chk32("stall_hold_pc", s_pc, hold_pc);
        chk1("stall_req_blocked", s_rv, 1'b0);
        stall = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // Memory not ready for 3 cycles: address holds at 0x10
        do_redirect(32'h10);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk32("addr_hold", s_addr, 32'h10);
        end
        imem_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // 3-cycle memory, redirect with requests in flight
        lat = 3;
        do_redirect(32'h0);
        for (int k = 0; k < 4; k++) step();
        do_redirect(32'h200);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        chk1("redir_valid_seen", found, 1'b1);
        chk32("redir_first_pc", s_pc, 32'h200);
        for (int k = 0; k < 6; k++) step();

        // Unaligned redirect target
        do_redirect(32'h103);
        step();
        chk32("redir_align", s_addr, 32'h100);

        // Redirect coinciding with a response and a stall
        lat   = 2;
        stall = 1'b1;
        for (int k = 0; k < 20 && !imem_rsp_valid; k++) step();
        chk1("rsp_for_redirect", imem_rsp_valid, 1'b1);
        do_redirect(32'h400);
        step();
        chk1("flush_next_empty", s_valid, 1'b0);
        stall = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // Fill the FIFO under stall, then reset mid-stream
        lat   = 1;
        stall = 1'b1;
        for (int k = 0; k < 12; k++) step();
        chk1("full_valid", s_valid, 1'b1);
        do_reset();
        stall = 1'b0;
        step();
        chk32("refetch_addr", s_addr, RESET_PC);
        chk1("refetch_valid", s_rv, 1'b1);

        // Randomized traffic against the reference model
        for (int k = 0; k < 500; k++) begin
            stall          = ($urandom_range(0, 9) < 3);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            lat            = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) begin
                do_redirect($urandom);
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
